btn_event_gen: RTL and testbench
================================

BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 Parameter LONG_CYCLES, default 8: number of cycles clean must stay high before a long press is declared (legal range >= 2).
REQ-002 Parameter REPEAT_CYCLES, default 4: auto-repeat period in cycles once the long press is declared (legal range >= 2).
REQ-003 Parameter CNT_W, default 8: width of the press counter.
REQ-004 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clean  input  1  debounced, clk-synchronous button level from the upstream debouncer (1 = pressed).
REQ-007 clr_count  input  1  synchronous clear of press_count.
REQ-008 press_pulse  output  1  one-cycle strobe when a press begins.
REQ-009 release_pulse  output  1  one-cycle strobe when a press ends.
REQ-010 long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.
REQ-011 repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES while held long.
REQ-012 held  output  1  level, high while the FSM is in HELD.
REQ-013 press_count  output  CNT_W  running count of presses.

Function
REQ-014 The FSM SHALL use three states: IDLE, PRESS and HELD.
REQ-015 IDLE -> PRESS: on the cycle clean is sampled 1; press_pulse SHALL be high in the following cycle only, so latency is 1 cycle.
REQ-016 PRESS: hold counter increments each cycle; at LONG_CYCLES-1 with clean still 1 -> HELD, long_pulse for one cycle, hold counter cleared.
REQ-017 HELD: hold counter increments each cycle; at REPEAT_CYCLES-1 -> repeat_pulse for one cycle and counter wraps to 0.
REQ-018 Any state with clean sampled 0 after PRESS/HELD -> IDLE, release_pulse for one cycle, hold counter cleared.
REQ-019 A release and a counter terminal value in the same cycle SHALL resolve as release only: no long_pulse or repeat_pulse.
REQ-020 All pulse outputs SHALL be registered, and at most one of press_pulse, release_pulse and long_pulse SHALL be high in any cycle.
REQ-021 press_count SHALL increment on press_pulse and wrap modulo 2^CNT_W.
REQ-022 clr_count together with a press in the same cycle SHALL give press_count = 1; clr_count alone SHALL give 0.
REQ-023 The hold counter width SHALL be clog2(max(LONG_CYCLES, REPEAT_CYCLES)); it SHALL never overflow.

Reset
REQ-024 rst_n low SHALL immediately force the state to IDLE, set all pulses, held, the hold counter and press_count to 0, and set the edge register to 0.
REQ-025 A reset asserted mid-press SHALL emit no release_pulse; after deassertion with clean still 1, a new press_pulse SHALL follow 1 cycle later.

Configuration
REQ-026 Macro BTN_AUTO_REPEAT_EN defined: REQ-017 applies.
REQ-027 Macro BTN_AUTO_REPEAT_EN undefined: repeat_pulse SHALL be tied 0 and the hold counter SHALL stop in HELD; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package btn_event_pkg SHALL hold the state typedef (IDLE/PRESS/HELD) and default parameter constants.
REQ-029 Sub-module btn_edge_detect SHALL register clean and produce the rise and fall strobes; btn_event_gen SHALL instantiate it once.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4)
REQ-030 clean high for 3 cycles then low -> press_pulse 1 cycle after the rise, release_pulse 1 cycle after the fall, no long_pulse, press_count=1.
REQ-031 clean high for 20 cycles -> long_pulse 8 cycles after press_pulse, repeat_pulse every 4 cycles thereafter (2 pulses), held high until release.
REQ-032 clean falls exactly on the cycle the counter reaches 7 -> release_pulse only, no long_pulse.
REQ-033 17 short presses -> press_count wraps to 1; clr_count coincident with the 18th press -> press_count=1.
REQ-034 rst_n pulsed low during HELD with clean high -> all outputs 0 asynchronously, no release_pulse, press_pulse 1 cycle after rst_n rises.
REQ-035 Rebuild without BTN_AUTO_REPEAT_EN and repeat REQ-031 -> long_pulse unchanged, repeat_pulse never asserted.

Source files
------------

// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared types and default constants for the button event generator.
package btn_event_pkg;

  // Button FSM states: waiting, pressed (short so far), held long.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_t;

  localparam int DEF_LONG_CYCLES   = 8;
  localparam int DEF_REPEAT_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: registers the debounced level and flags its rising and falling edges.
// The strobes are combinational against the registered copy, so the FSM can act on
// an edge in the very cycle it appears.
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  // Remember last cycle's level; cleared on reset so a level already high counts as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns a debounced button level into press / release / long-press /
// auto-repeat strobes plus a running press counter.
// Build option: define BTN_AUTO_REPEAT_EN to enable auto-repeat pulses while held.
// Without it, repeat_pulse is tied low and the hold counter parks in HELD.
// The current FSM state is exported on state_dbg for observation.
module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clean,
  input  logic             clr_count,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count,
  output logic [1:0]       state_dbg
);

  // Hold counter only ever reaches max(LONG, REPEAT)-1, so clog2 of the max is enough.
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rise;
  logic              fall;
  logic              press_evt;
  logic              repeat_q;

  btn_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (clean),
    .rise  (rise),
    .fall  (fall)
  );

  // A press is recognised in the cycle the rise is seen while idle.
  assign press_evt = (state == IDLE) && rise;
  assign state_dbg = state;

  // Button FSM: one transition per cycle, so press/release/long strobes are mutually exclusive.
  // Release is checked first so it wins over a counter reaching its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_q      <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state       <= PRESS;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        PRESS: begin
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            state      <= HELD;
            long_pulse <= 1'b1;
            held       <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        HELD: begin
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            hold_cnt      <= '0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (hold_cnt == REPEAT_LAST) begin
            repeat_q <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
`endif
        end
        default: begin
          state    <= IDLE;
          held     <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  // Press counter: updates on the press event so the new value appears alongside press_pulse.
  // A clear in the same cycle as a press leaves the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_count <= '0;
    end else if (clr_count) begin
      press_count <= press_evt ? CNT_W'(1) : '0;
    end else if (press_evt) begin
      press_count <= press_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed scenarios plus randomized button activity, compared every
// cycle against a run-length model of the button (how long clean has stayed high).
module tb_btn_event_gen;

  localparam int L  = 8;
  localparam int R  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clean = 1'b0;
  logic          clr_count = 1'b0;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_pulse;
  logic          repeat_pulse;
  logic          held;
  logic [CW-1:0] press_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  btn_event_gen #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clean         (clean),
    .clr_count     (clr_count),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count),
    .state_dbg     (state_dbg)
  );

  // Reference model: tracks whether the button is down and how many cycles
  // it has stayed high since the press; events follow from that length.
  logic          m_pressed = 1'b0;
  int            m_len = 0;
  logic          m_press = 1'b0;
  logic          m_rel = 1'b0;
  logic          m_long = 1'b0;
  logic          m_rep = 1'b0;
  logic          m_held = 1'b0;
  logic [CW-1:0] m_count = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pressed = 1'b0; m_len = 0; m_press = 1'b0; m_rel = 1'b0;
      m_long = 1'b0; m_rep = 1'b0; m_held = 1'b0; m_count = '0;
    end else begin
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_rep = 1'b0;
      if (!m_pressed && clean) begin
        m_pressed = 1'b1;
        m_len = 0;
        m_press = 1'b1;
      end else if (m_pressed && !clean) begin
        m_pressed = 1'b0;
        m_rel = 1'b1;
      end else if (m_pressed) begin
        m_len = m_len + 1;
        m_long = (m_len == L);
`ifdef BTN_AUTO_REPEAT_EN
        m_rep = (m_len > L) && (((m_len - L) % R) == 0);
`endif
      end
      m_held = m_pressed && (m_len >= L);
      m_count = clr_count ? CW'(m_press) : m_count + CW'(m_press);
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard statistics for the directed scenarios
  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0, n_held = 0;
  int press_cyc = 0, rel_cyc = 0, long_cyc = 0;

  // Compare process: every falling edge, DUT outputs against the model
  always @(negedge clk) begin
    cyc++;
    check_eq("press_pulse",   32'(press_pulse),   32'(m_press));
    check_eq("release_pulse", 32'(release_pulse), 32'(m_rel));
    check_eq("long_pulse",    32'(long_pulse),    32'(m_long));
    check_eq("repeat_pulse",  32'(repeat_pulse),  32'(m_rep));
    check_eq("held",          32'(held),          32'(m_held));
    check_eq("press_count",   32'(press_count),   32'(m_count));
    if (press_pulse === 1'b1)   begin n_press++; press_cyc = cyc; end
    if (release_pulse === 1'b1) begin n_rel++;   rel_cyc = cyc;   end
    if (long_pulse === 1'b1)    begin n_long++;  long_cyc = cyc;  end
    if (repeat_pulse === 1'b1)  n_rep++;
    if (held === 1'b1)          n_held++;
  end

  // Driver tasks: inputs change 2 time units after the rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_held = 0;
  endtask

  task automatic press(input int hi, input int lo);
    clean = 1'b1;
    step(hi);
    clean = 1'b0;
    step(lo);
  endtask

  int seg_len;

  initial begin
    step(3);
    check_eq("reset_count", 32'(press_count), 32'd0);
    check_eq("reset_held",  32'(held),        32'd0);
    rst_n = 1'b1;
    step(2);

    // Short press: 3 cycles high
    clear_stats();
    press(3, 3);
    check_eq("short_n_press", n_press, 1);
    check_eq("short_n_rel",   n_rel,   1);
    check_eq("short_n_long",  n_long,  0);
    check_eq("short_rel_lat", rel_cyc - press_cyc, 3);
    check_eq("short_count",   32'(press_count), 32'd1);

    // Long hold: 20 cycles high
    clear_stats();
    press(20, 3);
    check_eq("long_n_long", n_long, 1);
    check_eq("long_delay",  long_cyc - press_cyc, 8);
`ifdef BTN_AUTO_REPEAT_EN
    check_eq("long_n_rep", n_rep, 2);
`else
    check_eq("long_n_rep", n_rep, 0);
`endif
    check_eq("long_n_held", n_held, 12);
    check_eq("long_n_rel",  n_rel, 1);
    check_eq("long_count",  32'(press_count), 32'd2);

    // Release on the terminal count: release only
    clear_stats();
    press(8, 3);
    check_eq("edge_n_long", n_long, 0);
    check_eq("edge_n_rel",  n_rel,  1);
    check_eq("edge_n_held", n_held, 0);

    // Counter clear, 17 presses wrap to 1, clear together with a press gives 1
    clr_count = 1'b1;
    step(1);
    clr_count = 1'b0;
    check_eq("clr_alone", 32'(press_count), 32'd0);
    for (int i = 0; i < 17; i++) press(2, 2);
    check_eq("wrap_count", 32'(press_count), 32'd1);
    clean = 1'b1;
    clr_count = 1'b1;
    step(1);
    clr_count = 1'b0;
    check_eq("clr_with_press", 32'(press_count), 32'd1);
    step(1);
    clean = 1'b0;
    step(2);

    // Reset during HELD with clean high
    clean = 1'b1;
    step(12);
    check_eq("pre_rst_held", 32'(held), 32'd1);
    clear_stats();
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_outs",
             32'({press_pulse, release_pulse, long_pulse, repeat_pulse, held}), 32'd0);
    check_eq("rst_async_count", 32'(press_count), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check_eq("rst_repress", 32'(press_pulse), 32'd1);
    check_eq("rst_no_rel",  n_rel, 0);
    clean = 1'b0;
    step(3);

    // Randomized activity with occasional clears and asynchronous resets
    for (int s = 0; s < 80; s++) begin
      clean = 1'($urandom_range(0, 1));
      seg_len = $urandom_range(1, 16);
      for (int k = 0; k < seg_len; k++) begin
        clr_count = ($urandom_range(0, 9) == 0);
        step(1);
      end
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end
    clr_count = 1'b0;
    clean = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
